// File: rtl/lcd_bus_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_bus_receiver_if                                                  |
// | HD44780 4-bit bus: RS + DB7..DB4 on LCD_D, enable strobe on LCD_E.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lcd_bus_receiver_if;
  logic [4:0] LCD_D;
  logic       LCD_E;

  modport master (output LCD_D, output LCD_E);
  modport slave  (input  LCD_D, input  LCD_E);
endinterface
`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_bus_receiver                                                     |
// | HD44780 bus sniffer: nibble reassembly, mode tracking, DDRAM cursor. |
// | Optional gap checker: define LCD_RX_TIMING_CHECK_EN.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lcd_bus_receiver #(
  parameter int FREQ        = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int T_EXEC_US   = 37,
  parameter int T_CLEAR_US  = 1520
) (
  input  wire logic            CLK,
  input  wire logic            RST_N,
  lcd_bus_receiver_if.slave    lcd,
  output logic [7:0]           byte_out,
  output logic                 byte_rs,
  output logic                 byte_valid,
  output logic                 mode4bit,
  output logic [6:0]           cursor_addr,
  output logic                 line,
  output logic                 rs_err,
  output logic                 timing_err
);

  localparam logic [20:0] c_EXEC_CYC  = 21'(64'(T_EXEC_US)  * 64'(FREQ) / 64'd1000000);
  localparam logic [20:0] c_CLEAR_CYC = 21'(64'(T_CLEAR_US) * 64'(FREQ) / 64'd1000000);

  typedef enum logic [1:0] {
    MODE8 = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]      r_eSync;
  logic [SYNC_STAGES-1:0][4:0] r_dSync;
  logic                        r_ePrev;
  logic [4:0]                  r_capD;
  state_t                      r_state, w_stateNext;
  logic [3:0]                  r_hiNib;
  logic                        r_hiRs;
  logic                        r_id, w_idNext;
  logic [6:0]                  r_addr, w_addrNext;
  logic                        w_eS, w_eFall, w_emit, w_rsErr, w_storeHigh, w_mode4Next, w_rs;
  logic [4:0]                  w_dS;
  logic [7:0]                  w_byte;

  assign w_eS    = r_eSync[SYNC_STAGES-1];
  assign w_dS    = r_dSync[SYNC_STAGES-1];
  assign w_eFall = !w_eS && r_ePrev;
  assign w_rs    = r_capD[4];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_eSync <= '0;
      r_dSync <= '0;
      r_ePrev <= 1'b0;
      r_capD  <= '0;
    end else begin
      r_eSync <= {r_eSync[SYNC_STAGES-2:0], lcd.LCD_E};
      r_dSync <= {r_dSync[SYNC_STAGES-2:0], lcd.LCD_D};
      r_ePrev <= w_eS;
      // Keeps the bus value from the last cycle the synced strobe was high.
      if (w_eS)
        r_capD <= w_dS;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= MODE8;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_emit      = 1'b0;
    w_rsErr     = 1'b0;
    w_storeHigh = 1'b0;
    w_mode4Next = mode4bit;
    w_byte      = {r_capD[3:0], 4'h0};
    if (w_eFall) begin
      case (r_state)
        MODE8: begin
          w_emit = 1'b1;
          if (!r_capD[4] && r_capD[3:0] == 4'h2) begin
            w_stateNext = HIGH;
            w_mode4Next = 1'b1;
          end
        end
        HIGH: begin
          w_storeHigh = 1'b1;
          w_stateNext = LOW;
        end
        LOW: begin
          w_byte      = {r_hiNib, r_capD[3:0]};
          w_stateNext = HIGH;
          if (r_capD[4] == r_hiRs) begin
            w_emit = 1'b1;
            // Function set with DL=1 drops the controller back to 8-bit.
            if (!r_capD[4] && w_byte[7:5] == 3'b001 && w_byte[4]) begin
              w_stateNext = MODE8;
              w_mode4Next = 1'b0;
            end
          end else begin
            w_rsErr = 1'b1;
          end
        end
        default: w_stateNext = MODE8;
      endcase
    end
  end

  always_comb begin
    w_addrNext = r_addr;
    w_idNext   = r_id;
    if (w_emit) begin
      if (w_rs) begin
        // DDRAM is two 40-byte lines at 0x00-0x27 and 0x40-0x67.
        if (r_id)
          w_addrNext = (r_addr == 7'h27) ? 7'h40 : (r_addr == 7'h67) ? 7'h00 : r_addr + 7'd1;
        else
          w_addrNext = (r_addr == 7'h00) ? 7'h67 : (r_addr == 7'h40) ? 7'h27 : r_addr - 7'd1;
      end else if (w_byte == 8'h01) begin
        w_addrNext = 7'h00;
        w_idNext   = 1'b1;
      end else if (w_byte[7:1] == 7'b0000001) begin
        w_addrNext = 7'h00;
      end else if (w_byte[7:2] == 6'b000001) begin
        w_idNext = w_byte[1];
      end else if (w_byte[7]) begin
        w_addrNext = w_byte[6:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_out   <= 8'h00;
      byte_rs    <= 1'b0;
      byte_valid <= 1'b0;
      mode4bit   <= 1'b0;
      rs_err     <= 1'b0;
      r_hiNib    <= 4'h0;
      r_hiRs     <= 1'b0;
      r_id       <= 1'b1;
      r_addr     <= 7'h00;
    end else begin
      byte_valid <= w_emit;
      rs_err     <= w_rsErr;
      mode4bit   <= w_mode4Next;
      r_id       <= w_idNext;
      r_addr     <= w_addrNext;
      if (w_emit) begin
        byte_out <= w_byte;
        byte_rs  <= w_rs;
      end
      if (w_storeHigh) begin
        r_hiNib <= r_capD[3:0];
        r_hiRs  <= r_capD[4];
      end
    end
  end

  assign cursor_addr = r_addr;
  assign line        = r_addr[6];

`ifdef LCD_RX_TIMING_CHECK_EN
  logic [20:0] r_gapCnt;
  logic        r_longGap;
  logic        r_timingErr;
  logic        w_eRise;
  logic [20:0] w_gapReq;

  assign w_eRise  = w_eS && !r_ePrev;
  assign w_gapReq = r_longGap ? c_CLEAR_CYC : c_EXEC_CYC;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // Starts saturated so the first byte after reset is never flagged.
      r_gapCnt    <= '1;
      r_longGap   <= 1'b0;
      r_timingErr <= 1'b0;
    end else begin
      if (w_emit) begin
        r_gapCnt  <= '0;
        r_longGap <= !w_rs && (w_byte == 8'h01 || w_byte == 8'h02 || w_byte == 8'h03);
      end else if (r_gapCnt != '1) begin
        r_gapCnt <= r_gapCnt + 21'd1;
      end
      if (w_eRise && (r_state == MODE8 || r_state == HIGH) && r_gapCnt < w_gapReq)
        r_timingErr <= 1'b1;
    end
  end

  assign timing_err = r_timingErr;
`else
  logic w_unusedTiming;
  assign w_unusedTiming = ^{c_EXEC_CYC, c_CLEAR_CYC};
  assign timing_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_bus_receiver                                                  |
// | Directed bench for lcd_bus_receiver (1 MHz clock => 1 cycle per us). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lcd_bus_receiver;

  logic       CLK;
  logic       RST_N;
  logic [7:0] byte_out;
  logic       byte_rs, byte_valid, mode4bit, line, rs_err, timing_err;
  logic [6:0] cursor_addr;

  int nPass = 0;
  int nChecks = 0;
  int validCount = 0;
  int rsErrCount = 0;

  lcd_bus_receiver_if lcd ();

  lcd_bus_receiver #(
    .FREQ        (1000000),
    .SYNC_STAGES (2),
    .T_EXEC_US   (37),
    .T_CLEAR_US  (1520)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .lcd         (lcd.slave),
    .byte_out    (byte_out),
    .byte_rs     (byte_rs),
    .byte_valid  (byte_valid),
    .mode4bit    (mode4bit),
    .cursor_addr (cursor_addr),
    .line        (line),
    .rs_err      (rs_err),
    .timing_err  (timing_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (byte_valid) validCount++;
    if (rs_err)     rsErrCount++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One E pulse; lat = cycles from the E fall to the first byte_valid, 0 if none.
  task automatic sendNib(input logic rs, input logic [3:0] n, output int lat);
    lcd.LCD_D = {rs, n};
    repeat (2) @(posedge CLK);
    #1 lcd.LCD_E = 1'b1;
    repeat (4) @(posedge CLK);
    #1 lcd.LCD_E = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK);
      #1;
      if (byte_valid && lat == 0) lat = i;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] b, input int gap,
                          output int latHi, output int latLo);
    sendNib(rs, b[7:4], latHi);
    sendNib(rs, b[3:0], latLo);
    idle(gap);
  endtask

  logic [3:0] initNib  [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
  logic [7:0] initByte [5] = '{8'h2C, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic       expTimingErr;

  initial begin
    int lh, ll, vc, ec;
`ifdef LCD_RX_TIMING_CHECK_EN
    expTimingErr = 1'b1;
`else
    expTimingErr = 1'b0;
`endif
    RST_N = 1'b0;
    lcd.LCD_E = 1'b0;
    lcd.LCD_D = 5'h00;
    idle(4);
    chk("rst_byte_out", {24'd0, byte_out}, 32'h00);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_mode4", {31'd0, mode4bit}, 32'd0);
    chk("rst_cursor", {25'd0, cursor_addr}, 32'h00);
    chk("rst_timing", {31'd0, timing_err}, 32'd0);
    RST_N = 1'b1;
    idle(4);

    // Power-up 8-bit nibbles then 4-bit instructions
    for (int i = 0; i < 4; i++) begin
      sendNib(1'b0, initNib[i], ll);
      idle(40);
      chk("init8_lat", ll, 3);
      chk("init8_byte", {24'd0, byte_out}, {24'd0, initNib[i], 4'h0});
    end
    chk("init_mode4", {31'd0, mode4bit}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      sendByte(1'b0, initByte[i], (initByte[i] == 8'h01) ? 1600 : 40, lh, ll);
      chk("init4_hi_lat", lh, 0);
      chk("init4_lo_lat", ll, 3);
      chk("init4_byte", {24'd0, byte_out}, {24'd0, initByte[i]});
    end
    chk("init_count", validCount, 9);
    chk("init_cursor", {25'd0, cursor_addr}, 32'h00);
    chk("init_mode4_end", {31'd0, mode4bit}, 32'd1);

    // 'A'
    sendByte(1'b1, 8'h41, 40, lh, ll);
    chk("A_lat", ll, 3);
    chk("A_byte", {24'd0, byte_out}, 32'h41);
    chk("A_rs", {31'd0, byte_rs}, 32'd1);
    chk("A_cursor", {25'd0, cursor_addr}, 32'h01);

    // Line wraps
    sendByte(1'b0, 8'hA7, 40, lh, ll);
    chk("setA7_cursor", {25'd0, cursor_addr}, 32'h27);
    sendByte(1'b1, 8'h42, 40, lh, ll);
    chk("wrap27_cursor", {25'd0, cursor_addr}, 32'h40);
    chk("wrap27_line", {31'd0, line}, 32'd1);
    sendByte(1'b0, 8'hE7, 40, lh, ll);
    chk("setE7_cursor", {25'd0, cursor_addr}, 32'h67);
    sendByte(1'b1, 8'h43, 40, lh, ll);
    chk("wrap67_cursor", {25'd0, cursor_addr}, 32'h00);
    chk("wrap67_line", {31'd0, line}, 32'd0);
    sendByte(1'b0, 8'h04, 40, lh, ll);
    sendByte(1'b1, 8'h44, 40, lh, ll);
    chk("dec00_cursor", {25'd0, cursor_addr}, 32'h67);
    sendByte(1'b0, 8'h06, 40, lh, ll);

    // RS mismatch between nibbles
    vc = validCount;
    ec = rsErrCount;
    sendNib(1'b1, 4'h4, lh);
    sendNib(1'b0, 4'h1, ll);
    idle(40);
    chk("rserr_pulses", rsErrCount - ec, 1);
    chk("rserr_no_valid", validCount - vc, 0);
    sendByte(1'b1, 8'h42, 40, lh, ll);
    chk("after_rserr_lat", ll, 3);
    chk("after_rserr_byte", {24'd0, byte_out}, 32'h42);
    chk("after_rserr_cursor", {25'd0, cursor_addr}, 32'h00);

    // Gap after clear: long enough, then too short
    sendByte(1'b0, 8'h01, 1600, lh, ll);
    sendByte(1'b0, 8'h06, 40, lh, ll);
    chk("gap1600_timing", {31'd0, timing_err}, 32'd0);
    sendByte(1'b0, 8'h01, 1000, lh, ll);
    sendByte(1'b0, 8'h06, 40, lh, ll);
    chk("gap1000_timing", {31'd0, timing_err}, {31'd0, expTimingErr});

    // Reset with a pending high nibble
    sendNib(1'b1, 4'h4, lh);
    chk("pending_hi_lat", lh, 0);
    RST_N = 1'b0;
    idle(3);
    chk("midrst_byte_out", {24'd0, byte_out}, 32'h00);
    chk("midrst_rs", {31'd0, byte_rs}, 32'd0);
    chk("midrst_mode4", {31'd0, mode4bit}, 32'd0);
    chk("midrst_cursor", {25'd0, cursor_addr}, 32'h00);
    chk("midrst_timing", {31'd0, timing_err}, 32'd0);
    RST_N = 1'b1;
    idle(3);
    sendNib(1'b0, 4'h3, ll);
    idle(10);
    chk("postrst_lat", ll, 3);
    chk("postrst_byte", {24'd0, byte_out}, 32'h30);
    chk("postrst_mode4", {31'd0, mode4bit}, 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Receive-side model of the HD44780 4-bit parallel bus that our LCD driver transmits on.
- Monitors LCD_D/LCD_E and follows the controller's interface-mode state (8-bit power-up, then 4-bit).
- Reassembles nibbles into instruction/data bytes and tracks the DDRAM cursor address.
- Used as a synthesizable bus sniffer (debug, loopback on board) and as the checking model in driver benches.

Parameters:
- FREQ, 50000000, CLK frequency in Hz.
- SYNC_STAGES, 2, synchronizer depth for LCD_E and LCD_D (minimum 2).
- T_EXEC_US, 37, minimum gap in µs after a normal instruction or data write.
- T_CLEAR_US, 1520, minimum gap in µs after clear display (0x01) or return home (0x02/0x03).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- LCD_D  in  5  bus; bit4 = RS, bits3:0 = DB7..DB4.
- LCD_E  in  1  enable strobe; data latched on its falling edge.
- byte_out  out  8  last received byte.
- byte_rs  out  1  RS of last byte (0 = instruction, 1 = data).
- byte_valid  out  1  one-cycle strobe when byte_out/byte_rs update.
- mode4bit  out  1  1 = 4-bit interface active.
- cursor_addr  out  7  tracked DDRAM address.
- line  out  1  equals cursor_addr[6].
- rs_err  out  1  one-cycle pulse on RS mismatch between the two nibbles of a byte.
- timing_err  out  1  sticky gap-violation flag.

Behaviour:
- Reset values (RST_N low, asynchronous):
  - byte_out = 0, byte_rs = 0, byte_valid = 0, mode4bit = 0.
  - cursor_addr = 0, line = 0, rs_err = 0, timing_err = 0.
  - Entry-mode I/D = 1, state = MODE8, all synchronizers cleared.
- Synchronization and sampling:
  - LCD_E and LCD_D pass through SYNC_STAGES flops.
  - Falling edge = synced E low while its previous sample was high.
  - Captured nibble/RS = synced LCD_D registered on the last cycle E was high.
- States:
  - MODE8: each E pulse is a complete byte {nib,4'b0}. Emit it.
    - If RS = 0 and nib = 4'h2: go to HIGH and set mode4bit = 1.
    - Otherwise stay in MODE8.
  - HIGH: store nib as the high nibble and store its RS. Go to LOW. No strobe.
  - LOW: form byte = {high,nib}.
    - If RS matches the stored RS: emit the byte.
    - If RS differs: pulse rs_err, drop the byte, no byte_valid.
    - Either way return to HIGH.
    - If the emitted byte is an instruction with byte[7:5] = 3'b001 and byte[4] (DL) = 1: go to MODE8 and clear mode4bit.
- Latency: byte_valid rises exactly SYNC_STAGES+1 CLK cycles after the LCD_E falling edge that completes the byte. Width is 1 cycle.
- Cursor tracking on each emitted byte (RS = 0 cases are instructions):
  - RS = 0, 0x01: cursor_addr = 0, I/D = 1.
  - RS = 0, 0x02 or 0x03: cursor_addr = 0.
  - RS = 0, 0x04-0x07: I/D = byte[1].
  - RS = 0, byte[7] = 1: cursor_addr = byte[6:0].
  - RS = 1: step the address by I/D. 0x27 increments to 0x40, 0x67 increments to 0x00. 0x00 decrements to 0x67, 0x40 decrements to 0x27.
  - Any other instruction: address unchanged.
  - Cursor updates in the same cycle as byte_valid.
- Edge cases:
  - E pulses of any width of at least SYNC_STAGES cycles are accepted.
  - Shorter pulses may be missed; this is not flagged.
  - RST_N assertion mid-byte discards the stored high nibble. The next byte is interpreted in MODE8.

Optional Feature:
- Macro: LCD_RX_TIMING_CHECK_EN.
- Defined:
  - A 21-bit counter restarts at each emitted byte.
  - The required gap is T_CLEAR_US*FREQ/1e6 cycles after 0x01-0x03 and T_EXEC_US*FREQ/1e6 cycles otherwise.
  - A synced E rising edge that starts the next byte (state MODE8 or HIGH) before the counter reaches the required gap sets timing_err. It stays set until reset.
  - The counter saturates at all-ones.
  - Nibble-to-nibble gaps within a byte are not checked.
- Undefined: no counter is built and timing_err is tied 0.

Test Plan:
- Driver init sequence (nibbles 0x3,0x3,0x3,0x2 then 0x2,0xC / 0x0,0x8 / 0x0,0x1 / 0x0,0x6 / 0x0,0xC, RS = 0):
  - byte_valid pulses with bytes 0x30,0x30,0x30,0x20,0x2C,0x08,0x01,0x06,0x0C.
  - mode4bit = 1 after the fourth pulse.
  - cursor_addr = 0.
- After init, data nibbles 0x14,0x11 (RS = 1, 'A'):
  - byte_out = 0x41, byte_rs = 1, cursor_addr = 1.
  - byte_valid occurs 3 cycles after the second LCD_E fall.
- Instruction 0xA7 then one data byte: cursor_addr = 0x27, then 0x40, line = 1.
  - Same with 0xE7: wraps to 0x00.
  - Entry mode 0x04 at address 0x00: next data byte → 0x67.
- High nibble with RS = 1 and low nibble with RS = 0:
  - rs_err pulses once, no byte_valid.
  - The next well-formed byte decodes normally.
- With LCD_RX_TIMING_CHECK_EN:
  - Clear (0x01), then a new byte 1000 µs later: timing_err = 1.
  - Same with a 1600 µs gap: timing_err stays 0.
  - Without the macro, timing_err = 0 in both cases.
- Reset during LOW state after high nibble 0x4 (RS = 1):
  - All outputs return to their reset values and mode4bit = 0.
  - The next nibble 0x3 yields byte 0x30.
